// File: rtl/pipelined_adder_if.sv
`default_nettype none
// ============================================================================
//  Module   : pipelined_adder_if
//  Purpose  : Operand/result stream bundle for pipelined_adder.
//  Revision : 1.0 - initial release
// ============================================================================
interface pipelined_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry;

  // master: the producer/consumer around the adder; slave: the adder itself
  modport master (
    output in_valid, a, b, ci, out_ready,
    input  in_ready, out_valid, result, carry
  );

  modport slave (
    input  in_valid, a, b, ci, out_ready,
    output in_ready, out_valid, result, carry
  );
endinterface
`default_nettype wire

// File: rtl/pipelined_adder.sv
`default_nettype none
// ============================================================================
//  Module   : pipelined_adder
//  Purpose  : Chunked ripple-carry adder, one chunk per stage, valid/ready on
//             both sides. Define PIPELINED_ADDER_SAT_EN to saturate on carry.
//  Revision : 1.0 - initial release
// ============================================================================
module pipelined_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  wire logic            clk,
  input  wire logic            reset,
  pipelined_adder_if.slave     bus
);

  localparam int c_CW = WIDTH / STAGES;

  if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("pipelined_adder: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
  end

  logic             r_out_valid;
  logic             r_carry;
  logic [WIDTH-1:0] r_result;
  logic             w_adv;
  logic [WIDTH-1:0] w_result_nxt;

  // Whole pipe moves as one; only out_ready reaches in_ready combinationally.
  assign w_adv        = ~r_out_valid | bus.out_ready;
  assign bus.in_ready = w_adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Stage k sees only the operand bits not yet summed and emits a sum that
    // grows by one chunk, so no register carries bits nobody reads.
    localparam int c_OPW = WIDTH - k * c_CW;
    localparam int c_SW  = (k + 1) * c_CW;

    logic [c_OPW-1:0] w_a_in;
    logic [c_OPW-1:0] w_b_in;
    logic             w_c_in;
    logic             w_v_in;
    logic [c_CW:0]    w_chunk;
    logic [c_SW-1:0]  w_sum_nxt;

    logic             r_vld;
    logic             r_cy;
    logic [c_SW-1:0]  r_sum;

    if (k == 0) begin : g_head
      assign w_a_in    = bus.a;
      assign w_b_in    = bus.b;
      assign w_c_in    = bus.ci;
      assign w_v_in    = bus.in_valid & w_adv;
      assign w_sum_nxt = w_chunk[c_CW-1:0];
    end else begin : g_body
      assign w_a_in    = g_stage[k-1].g_fwd.r_a;
      assign w_b_in    = g_stage[k-1].g_fwd.r_b;
      assign w_c_in    = g_stage[k-1].r_cy;
      assign w_v_in    = g_stage[k-1].r_vld;
      assign w_sum_nxt = {w_chunk[c_CW-1:0], g_stage[k-1].r_sum};
    end

    assign w_chunk = {1'b0, w_a_in[c_CW-1:0]}
                   + {1'b0, w_b_in[c_CW-1:0]}
                   + {{c_CW{1'b0}}, w_c_in};

    always_ff @(posedge clk) begin
      if (reset) begin
        r_vld <= 1'b0;
      end else if (w_adv) begin
        r_vld <= w_v_in;
      end
    end

    always_ff @(posedge clk) begin
      if (w_adv) begin
        r_cy  <= w_chunk[c_CW];
        r_sum <= w_sum_nxt;
      end
    end

    // Upper operand chunks ride along until their own stage is reached.
    if (k < STAGES - 1) begin : g_fwd
      logic [c_OPW-c_CW-1:0] r_a;
      logic [c_OPW-c_CW-1:0] r_b;

      always_ff @(posedge clk) begin
        if (w_adv) begin
          r_a <= w_a_in[c_OPW-1:c_CW];
          r_b <= w_b_in[c_OPW-1:c_CW];
        end
      end
    end
  end

`ifdef PIPELINED_ADDER_SAT_EN
  assign w_result_nxt = g_stage[STAGES-1].r_cy ? '1 : g_stage[STAGES-1].r_sum;
`else
  assign w_result_nxt = g_stage[STAGES-1].r_sum;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_carry     <= 1'b0;
    end else if (w_adv) begin
      r_out_valid <= g_stage[STAGES-1].r_vld;
      r_result    <= w_result_nxt;
      r_carry     <= g_stage[STAGES-1].r_cy;
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.carry     = r_carry;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_adder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipelined_adder
//  Purpose  : Directed self-checking bench for pipelined_adder (four configs).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipelined_adder;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

`ifdef PIPELINED_ADDER_SAT_EN
  localparam logic [7:0] c_CC_RESULT = 8'hFF;
`else
  localparam logic [7:0] c_CC_RESULT = 8'h00;
`endif

  pipelined_adder_if #(.WIDTH(16)) bus_a ();
  pipelined_adder_if #(.WIDTH(8))  bus_b ();
  pipelined_adder_if #(.WIDTH(4))  bus_c ();
  pipelined_adder_if #(.WIDTH(4))  bus_d ();

  pipelined_adder #(.WIDTH(16), .STAGES(4)) u_a (.clk(clk), .reset(reset), .bus(bus_a.slave));
  pipelined_adder #(.WIDTH(8),  .STAGES(2)) u_b (.clk(clk), .reset(reset), .bus(bus_b.slave));
  pipelined_adder #(.WIDTH(4),  .STAGES(1)) u_c (.clk(clk), .reset(reset), .bus(bus_c.slave));
  pipelined_adder #(.WIDTH(4),  .STAGES(4)) u_d (.clk(clk), .reset(reset), .bus(bus_d.slave));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference for the 4-bit configs: v = {ci, b, a}
  function automatic logic [4:0] model4(input logic [8:0] v);
    logic [4:0] s;
    s = {1'b0, v[3:0]} + {1'b0, v[7:4]} + {4'b0000, v[8]};
`ifdef PIPELINED_ADDER_SAT_EN
    if (s[4]) s = 5'h1F;
`endif
    return s;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int         cnt;
    int         ic, id, oc, od;
    bit         acc_c, acc_d;
    logic [8:0] vc, vd;

    bus_a.in_valid = 1'b0; bus_a.a = '0; bus_a.b = '0; bus_a.ci = 1'b0; bus_a.out_ready = 1'b1;
    bus_b.in_valid = 1'b0; bus_b.a = '0; bus_b.b = '0; bus_b.ci = 1'b0; bus_b.out_ready = 1'b1;
    bus_c.in_valid = 1'b0; bus_c.a = '0; bus_c.b = '0; bus_c.ci = 1'b0; bus_c.out_ready = 1'b1;
    bus_d.in_valid = 1'b0; bus_d.a = '0; bus_d.b = '0; bus_d.ci = 1'b0; bus_d.out_ready = 1'b1;

    // ---- reset with a live input held on the 16/4 adder
    reset = 1'b1;
    bus_a.in_valid = 1'b1; bus_a.a = 16'h0005; bus_a.b = 16'h0007;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", 32'(bus_a.out_valid), 32'h0);
      check("rst_result",    32'(bus_a.result),    32'h0);
      check("rst_carry",     32'(bus_a.carry),     32'h0);
    end
    reset = 1'b0;
    bus_a.in_valid = 1'b0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus_a.out_valid) cnt++;
    end
    check("rst_no_emerge", 32'(cnt), 32'h0);
    check("rst_in_ready",  32'(bus_a.in_ready), 32'h1);

    // ---- latency on the 8/2 adder
    tick();
    bus_b.in_valid = 1'b1; bus_b.a = 8'h0F; bus_b.b = 8'h01; bus_b.ci = 1'b0;
    @(negedge clk);
    check("lat_in_ready", 32'(bus_b.in_ready), 32'h1);
    tick();
    bus_b.in_valid = 1'b0;
    @(negedge clk);
    check("lat_edge0_valid", 32'(bus_b.out_valid), 32'h0);
    @(negedge clk);
    check("lat_edge1_valid", 32'(bus_b.out_valid), 32'h0);
    @(negedge clk);
    check("lat_edge2_valid", 32'(bus_b.out_valid), 32'h1);
    check("lat_result",      32'(bus_b.result),    32'h10);
    check("lat_carry",       32'(bus_b.carry),     32'h0);

    // ---- carry crossing the chunk boundary
    tick();
    bus_b.in_valid = 1'b1; bus_b.a = 8'hFF; bus_b.b = 8'h00; bus_b.ci = 1'b1;
    tick();
    bus_b.in_valid = 1'b0;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!bus_b.out_valid && cnt < 10);
    check("cc_valid",   32'(bus_b.out_valid), 32'h1);
    check("cc_latency", 32'(cnt),             32'h3);
    check("cc_result",  32'(bus_b.result),    32'(c_CC_RESULT));
    check("cc_carry",   32'(bus_b.carry),     32'h1);

    // ---- back-pressure on the 16/4 adder
    tick();
    fork
      begin : drv
        for (int i = 1; i <= 6; i++) begin
          bit acc;
          int budget;
          bus_a.in_valid = 1'b1;
          bus_a.a = 16'(i);
          bus_a.b = 16'(2 * i);
          bus_a.ci = 1'b0;
          acc = 1'b0;
          budget = 0;
          while (!acc && budget < 50) begin
            @(negedge clk);
            #2;
            acc = bus_a.in_valid && bus_a.in_ready;
            @(posedge clk);
            #1;
            budget++;
          end
          if (!acc) check("bp_accept_timeout", 32'(acc), 32'h1);
        end
        bus_a.in_valid = 1'b0;
      end
      begin : mon
        int got;
        int hold;
        bit seen;
        got = 0; hold = 0; seen = 1'b0;
        for (int cyc = 0; cyc < 80 && got < 6; cyc++) begin
          @(negedge clk);
          if (bus_a.out_valid && !seen) begin
            seen = 1'b1;
            bus_a.out_ready = 1'b0;
            #1;
            check("bp_in_ready_low", 32'(bus_a.in_ready), 32'h0);
            check("bp_first_result", 32'(bus_a.result),   32'h3);
            hold = 5;
          end else if (hold > 0) begin
            check("bp_held_valid",  32'(bus_a.out_valid), 32'h1);
            check("bp_held_result", 32'(bus_a.result),    32'h3);
            check("bp_held_ready",  32'(bus_a.in_ready),  32'h0);
            hold--;
            if (hold == 0) bus_a.out_ready = 1'b1;
          end
          if (bus_a.out_valid && bus_a.out_ready) begin
            check("bp_order", 32'(bus_a.result), 32'(3 * (got + 1)));
            check("bp_carry", 32'(bus_a.carry),  32'h0);
            got++;
          end
        end
        check("bp_count", 32'(got), 32'h6);
      end
    join
    bus_a.out_ready = 1'b1;
    repeat (8) tick();

    // ---- mid-flight reset: three accepted, reset one cycle after the last
    for (int i = 1; i <= 3; i++) begin
      bus_a.in_valid = 1'b1; bus_a.a = 16'(i); bus_a.b = 16'(i); bus_a.ci = 1'b0;
      tick();
    end
    bus_a.in_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus_a.out_valid) cnt++;
    end
    check("mid_rst_flushed", 32'(cnt), 32'h0);
    tick();
    bus_a.in_valid = 1'b1; bus_a.a = 16'h1234; bus_a.b = 16'h1111; bus_a.ci = 1'b0;
    tick();
    bus_a.in_valid = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      check("mid_rst_valid", 32'(bus_a.out_valid), 32'(n == 5));
    end
    check("mid_rst_result", 32'(bus_a.result), 32'h2345);
    check("mid_rst_carry",  32'(bus_a.carry),  32'h0);

    // ---- exhaustive 4-bit, one and four stages, random out_ready
    tick();
    ic = 0; id = 0; oc = 0; od = 0;
    for (int cyc = 0; cyc < 6000 && (oc < 512 || od < 512); cyc++) begin
      vc = ic[8:0];
      vd = id[8:0];
      bus_c.in_valid = (ic < 512); bus_c.a = vc[3:0]; bus_c.b = vc[7:4]; bus_c.ci = vc[8];
      bus_d.in_valid = (id < 512); bus_d.a = vd[3:0]; bus_d.b = vd[7:4]; bus_d.ci = vd[8];
      bus_c.out_ready = 1'($urandom_range(0, 1));
      bus_d.out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc_c = bus_c.in_valid && bus_c.in_ready;
      acc_d = bus_d.in_valid && bus_d.in_ready;
      if (bus_c.out_valid && bus_c.out_ready) begin
        check("exh_s1_sum", 32'({bus_c.carry, bus_c.result}), 32'(model4(oc[8:0])));
        oc++;
      end
      if (bus_d.out_valid && bus_d.out_ready) begin
        check("exh_s4_sum", 32'({bus_d.carry, bus_d.result}), 32'(model4(od[8:0])));
        od++;
      end
      tick();
      if (acc_c) ic++;
      if (acc_d) id++;
    end
    check("exh_s1_count", 32'(oc), 32'd512);
    check("exh_s4_count", 32'(od), 32'd512);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined ripple-carry adder with valid/ready flow control on both sides. The operand width is split into equal chunks, one chunk per pipeline stage, and the carry is registered between stages. This gives one result per cycle at any width. It is the streaming replacement for the fixed 4-bit structural adders: datapath blocks feed operand pairs in and drain sum/carry pairs out in order.

## Interface
- `WIDTH`, default 16: operand and result width in bits; ≥ 1.
- `STAGES`, default 4: number of pipeline stages.
  - Must satisfy 1 ≤ `STAGES` ≤ `WIDTH` and `WIDTH % STAGES == 0`.
  - Chunk width `CW = WIDTH/STAGES`.
- `clk` input 1: single clock. All state updates on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `in_valid` input 1: an operand pair is presented.
- `in_ready` output 1: the block accepts the pair this cycle.
- `a` input `WIDTH`: operand A (unsigned).
- `b` input `WIDTH`: operand B (unsigned).
- `ci` input 1: carry in.
- `out_valid` output 1: `result`/`carry` hold a valid sum.
- `out_ready` input 1: the consumer accepts the result this cycle.
- `result` output `WIDTH`: sum, bits `WIDTH-1:0`.
- `carry` output 1: carry out of the MSB.

## Operation
- Global advance: `adv = !out_valid || out_ready`, and `in_ready = adv`.
  - When `adv = 0`, every stage register holds its value.
  - When `adv = 1`, all stages shift by one.
- Stage k (0 ≤ k < `STAGES`):
  - Registers `{c_k, s_k} = a_chunk_k + b_chunk_k + c_(k-1)`, using chunk bits `[k*CW +: CW]`.
  - `c_(-1)` is the accepted `ci`.
  - Each stage carries a valid bit. Stage 0 valid is `in_valid && in_ready`.
- Skew handling:
  - Operand chunks above stage k travel through delay registers alongside the data.
  - Finished lower sum chunks travel through delay registers as well.
  - All `WIDTH` bits of one transaction therefore emerge together.
- Output registers:
  - `out_valid` = last-stage valid.
  - `result` = concatenated sum chunks.
  - `carry` = `c_(STAGES-1)`.
- Ordering is strict FIFO. No transaction is dropped or duplicated.
- Bubbles (`in_valid = 0` while `adv = 1`) propagate as invalid stages. Data registers of invalid stages may update, but their contents are don't-care.
- Arithmetic is modulo 2^`WIDTH` with a separate carry. `result` and `carry` together equal `a + b + ci` exactly (`WIDTH+1` bits).

## Timing
- Reset values, effective on the first rising edge with `reset = 1`:
  - All stage valids = 0, `out_valid` = 0, `result` = 0, `carry` = 0.
  - `in_ready` = 1 from the cycle after reset.
- Reset mid-operation flushes all in-flight transactions. Nothing emerges afterwards.
- Latency: an operand accepted at edge N appears with `out_valid = 1` after edge N+`STAGES`, provided there is no back-pressure.
- Throughput: 1 transaction per cycle while `out_ready = 1`.
- Back-pressure:
  - With `out_valid = 1` and `out_ready = 0`, `in_ready` is 0 combinationally in the same cycle.
  - `result` and `carry` stay stable until accepted.
- Simultaneous events:
  - `out_ready = 1` with `in_valid = 1` on a full pipe: the output is consumed and a new input is accepted on the same edge.
  - `reset` overrides the handshake.
- Combinational paths: `out_ready → in_ready` only. No path from `a`, `b`, or `ci` to any output.

## Configuration
- `PIPELINED_ADDER_SAT_EN`:
  - Defined: when the final carry is 1, `result` is forced to all-ones; `carry` still reports 1.
  - Undefined: plain wrap-around sum.
  - Latency and handshake are identical in both builds.

## Test plan
- Reset (`WIDTH=16`, `STAGES=4`): hold `reset` for 2 cycles with `in_valid = 1`. Required: `out_valid = 0`, `result = 0`, `carry = 0`, and no output ever emerges from the inputs driven during reset.
- Latency (`WIDTH=8`, `STAGES=2`): `a=0x0F`, `b=0x01`, `ci=0` accepted at edge 0. Required: `out_valid = 1` after edge 2 with `result = 0x10`, `carry = 0`.
- Cross-stage carry (`WIDTH=8`, `STAGES=2`): `a=0xFF`, `b=0x00`, `ci=1`. Required: `result = 0x00`, `carry = 1`. With `PIPELINED_ADDER_SAT_EN` defined: `result = 0xFF`, `carry = 1`.
- Back-pressure (`WIDTH=16`, `STAGES=4`): stream 6 pairs (i, 2i), i = 1..6, with `out_ready` low for 5 cycles after the first output. Required:
  - `in_ready` falls in the same cycle.
  - The held output stays 0x0003.
  - Outputs arrive in order 3, 6, 9, 12, 15, 18, with none lost.
- Mid-flight reset (`WIDTH=16`, `STAGES=4`): accept 3 pairs, assert `reset` 1 cycle later. Required: no `out_valid` until new input; the next pair 0x1234 + 0x1111 yields 0x2345 after 4 cycles.
- Exhaustive (`WIDTH=4`, `STAGES=1` and `STAGES=4`): all 512 combinations of `a`, `b`, `ci` with random `out_ready`. Required: `{carry, result} == a + b + ci` for every transaction.
